main_fsm: RTL and testbench
===========================

Name: main_fsm

Overview:
- Multicycle main controller for the rv32i core UC; the producer side of the aluOp/f3/f7 interface consumed by the ALU decoder.
- Moore FSM sequences fetch/decode/execute/memory/writeback per instruction.
- Drives datapath mux selects, write enables and the 2-bit aluOp.
- Combinational immSrc decode from op.

Parameters:
- ILLEGAL_HALT, 1: 1 = unknown opcode enters sticky ILLEGAL until reset; 0 = ILLEGAL lasts one cycle, then FETCH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  instr[6:0] from IR; stable from DECODE until FETCH
- zero  in  1  ALU zero flag
- pcWrite  out  1  pcUpdate | (branch & zero)
- adrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- memWrite  out  1  data memory write enable
- irWrite  out  1  instruction/oldPC register load
- resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- aluSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- aluSrcB  out  2  00=rs2, 01=imm, 10=const 4
- regWrite  out  1  register file write enable
- aluOp  out  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
- immSrc  out  2  00=I, 01=S, 10=B, 11=J
- trap  out  1  high while in ILLEGAL
- state  out  4  current state encoding (debug)

Behaviour:
- Opcodes: LW 0000011, SW 0100011, R 0110011, I 0010011, BEQ 1100011, JAL 1101111.
- State register updates on the rising clk edge. All outputs except immSrc and pcWrite depend only on state; pcWrite also depends on zero.
- Reset: on any clk edge with rst_n=0, state<=FETCH. Also, while rst_n=0, pcWrite, irWrite, memWrite, regWrite and trap are forced 0 combinationally.
  - Reset mid-instruction aborts the instruction with no partial write after the reset edge.
- After rst_n rises, the first cycle is FETCH.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11.
  - Codes 12-15 transition to FETCH; their outputs are the defaults.
- Defaults: all enables 0, all selects 00.
- Per-state outputs (only non-default values listed):
  - FETCH: irWrite=1, pcUpdate=1, aluSrcB=10, resultSrc=10; aluOp=00.
  - DECODE: aluSrcA=01, aluSrcB=01; aluOp=00 (branch target precompute).
  - MEMADR: aluSrcA=10, aluSrcB=01; aluOp=00.
  - MEMREAD: adrSrc=1.
  - MEMWB: resultSrc=01, regWrite=1.
  - MEMWRITE: adrSrc=1, memWrite=1.
  - EXECR: aluSrcA=10, aluSrcB=00, aluOp=10.
  - EXECI: aluSrcA=10, aluSrcB=01, aluOp=10.
  - ALUWB: resultSrc=00, regWrite=1.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, branch=1.
  - JAL: aluSrcA=01, aluSrcB=10, pcUpdate=1.
  - ILLEGAL: trap=1, all enables 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: LW/SW -> MEMADR; R -> EXECR; I -> EXECI; BEQ -> BEQ; JAL -> JAL; other -> ILLEGAL.
  - MEMADR: LW -> MEMREAD; SW -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECR/EXECI -> ALUWB -> FETCH.
  - JAL -> ALUWB.
  - BEQ -> FETCH.
  - ILLEGAL -> ILLEGAL if ILLEGAL_HALT=1, else -> FETCH.
- Cycles per instruction: LW 5, SW 4, R/I 4, JAL 4, BEQ 3.
- branch and pcUpdate are internal. pcWrite asserts in BEQ only when zero=1; a zero change within the BEQ cycle is reflected combinationally.
- immSrc is combinational from op: LW/I 00, SW 01, BEQ 10, JAL 11, other 00.

Decomposition:
- Shared package/header `rv32i_defs`:
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - state encodings;
  - aluOp, resultSrc, aluSrcA/B and immSrc code constants (shared with the ALU decoder and datapath).
- Natural sub-module: `imm_src_deco` (combinational op -> immSrc).
- State register and output logic stay in main_fsm.

Test Plan:
- Reset: rst_n=0 for 2 cycles with op=0110011 -> state=0, pcWrite/irWrite/regWrite/memWrite all 0. Release -> first cycle irWrite=1, pcWrite=1, aluSrcB=10.
- R-type op=0110011: state sequence 0,1,6,8,0. aluOp=10 in EXECR. regWrite=1 only in ALUWB. 4 cycles.
- LW then SW:
  - op=0000011: 0,1,2,3,4,0; adrSrc=1 in MEMREAD; resultSrc=01 with regWrite=1 in MEMWB.
  - op=0100011: 0,1,2,5,0; memWrite=1 only in MEMWRITE; immSrc=01.
- BEQ op=1100011: in BEQ with zero=1 -> pcWrite=1, aluOp=01. Repeat with zero=0 -> pcWrite=0. Both 3-cycle sequences 0,1,9,0. immSrc=10.
- JAL op=1101111: 0,1,10,8,0. pcWrite=1 in JAL, regWrite=1 in ALUWB, immSrc=11.
- Illegal op=1111111:
  - ILLEGAL_HALT=1: state 11 held for 5+ cycles, trap=1, no enables; rst_n=0 -> FETCH.
  - ILLEGAL_HALT=0: trap pulses 1 cycle, then state 0.
  - Reset asserted during MEMWRITE: memWrite=0 immediately; state 0 after the edge.

Source files
------------

// File: rtl/rv32i_defs.sv
// Shared rv32i control definitions: opcodes, main FSM state codes, datapath
// select codes and the per-state control word used by the main controller.
package rv32i_defs;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic [1:0] alu_op;
      logic       trap;
   } ctrl_t;

   // Moore control word for a state; unlisted states keep the all-zero default.
   function automatic ctrl_t ctrl_for(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_update  = 1'b1;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
            c.alu_op     = ALUOP_ADD;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_SUB;
            c.branch    = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_FOUR;
            c.pc_update = 1'b1;
         end
         S_ILLEGAL: c.trap = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/imm_src_deco.sv
// Immediate-format select decoded directly from the opcode field.
module imm_src_deco
   import rv32i_defs::*;
(
   input  logic [6:0] op_i,
   output logic [1:0] imm_src_o
);

   always_comb begin
      imm_src_o = IMM_I;
      case (op_i)
         OP_SW:   imm_src_o = IMM_S;
         OP_BEQ:  imm_src_o = IMM_B;
         OP_JAL:  imm_src_o = IMM_J;
         default: imm_src_o = IMM_I;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle rv32i main controller: Moore FSM sequencing fetch through
// writeback, driving datapath selects, write enables and aluOp.
module main_fsm
   import rv32i_defs::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       regWrite,
   output logic [1:0] aluOp,
   output logic [1:0] immSrc,
   output logic       trap,
   output logic [3:0] state
);

   state_t state_q, state_d;
   ctrl_t  ctrl_q;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_ILLEGAL:  state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // Control word is registered alongside the state from the next-state value,
   // so it always matches state_q without a decode after the flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_for(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_for(state_d);
      end
   end

   // Enables are masked by rst_n so an asserted reset kills writes immediately.
   assign pcWrite   = rst_n & (ctrl_q.pc_update | (ctrl_q.branch & zero));
   assign memWrite  = rst_n & ctrl_q.mem_write;
   assign irWrite   = rst_n & ctrl_q.ir_write;
   assign regWrite  = rst_n & ctrl_q.reg_write;
   assign trap      = rst_n & ctrl_q.trap;
   assign adrSrc    = ctrl_q.adr_src;
   assign resultSrc = ctrl_q.result_src;
   assign aluSrcA   = ctrl_q.alu_src_a;
   assign aluSrcB   = ctrl_q.alu_src_b;
   assign aluOp     = ctrl_q.alu_op;
   assign state     = state_q;

   imm_src_deco u_imm_src_deco (
      .op_i      (op),
      .imm_src_o (immSrc)
   );

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: two instances (halting and non-halting illegal handling)
// driven in lockstep and compared against an instruction-level reference model.
module tb_main_fsm;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_BEQ = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       zero;

   logic       h_pcWrite, h_adrSrc, h_memWrite, h_irWrite, h_regWrite, h_trap;
   logic [1:0] h_resultSrc, h_aluSrcA, h_aluSrcB, h_aluOp, h_immSrc;
   logic [3:0] h_state;
   logic       p_pcWrite, p_adrSrc, p_memWrite, p_irWrite, p_regWrite, p_trap;
   logic [1:0] p_resultSrc, p_aluSrcA, p_aluSrcB, p_aluOp, p_immSrc;
   logic [3:0] p_state;

   logic [19:0] obs_h, obs_p, exp_v, exp_p;
   logic [3:0]  exp_q[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   main_fsm #(.ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
      .pcWrite(h_pcWrite), .adrSrc(h_adrSrc), .memWrite(h_memWrite),
      .irWrite(h_irWrite), .resultSrc(h_resultSrc), .aluSrcA(h_aluSrcA),
      .aluSrcB(h_aluSrcB), .regWrite(h_regWrite), .aluOp(h_aluOp),
      .immSrc(h_immSrc), .trap(h_trap), .state(h_state)
   );

   main_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
      .pcWrite(p_pcWrite), .adrSrc(p_adrSrc), .memWrite(p_memWrite),
      .irWrite(p_irWrite), .resultSrc(p_resultSrc), .aluSrcA(p_aluSrcA),
      .aluSrcB(p_aluSrcB), .regWrite(p_regWrite), .aluOp(p_aluOp),
      .immSrc(p_immSrc), .trap(p_trap), .state(p_state)
   );

   assign obs_h = {h_state, h_pcWrite, h_adrSrc, h_memWrite, h_irWrite, h_resultSrc,
                   h_aluSrcA, h_aluSrcB, h_regWrite, h_aluOp, h_immSrc, h_trap};
   assign obs_p = {p_state, p_pcWrite, p_adrSrc, p_memWrite, p_irWrite, p_resultSrc,
                   p_aluSrcA, p_aluSrcB, p_regWrite, p_aluOp, p_immSrc, p_trap};

   // Reference: what the controller must present in a given phase of an instruction.
   function automatic logic [19:0] exp_vec(int s, logic z, logic r, logic [6:0] o);
      logic pcw, adr, memw, irw, regw, trp;
      logic [1:0] res, sa, sb, aop, imm;
      pcw  = (s == 0) || (s == 10) || (s == 9 && z);
      adr  = (s == 3) || (s == 5);
      memw = (s == 5);
      irw  = (s == 0);
      regw = (s == 4) || (s == 8);
      trp  = (s == 11);
      res  = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
      sa   = (s == 1 || s == 10) ? 2'd1 : (s == 2 || s == 6 || s == 7 || s == 9) ? 2'd2 : 2'd0;
      sb   = (s == 0 || s == 10) ? 2'd2 : (s == 1 || s == 2 || s == 7) ? 2'd1 : 2'd0;
      aop  = (s == 6 || s == 7) ? 2'd2 : (s == 9) ? 2'd1 : 2'd0;
      imm  = (o == T_SW) ? 2'd1 : (o == T_BEQ) ? 2'd2 : (o == T_JAL) ? 2'd3 : 2'd0;
      if (!r) begin
         pcw = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0; trp = 1'b0;
      end
      return {4'(s), pcw, adr, memw, irw, res, sa, sb, regw, aop, imm, trp};
   endfunction

   // Expected state trace of one instruction, starting at its fetch.
   function automatic void load_trace(logic [6:0] o);
      exp_q = {};
      case (o)
         T_LW:    exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
         T_SW:    exp_q = {4'd0, 4'd1, 4'd2, 4'd5};
         T_R:     exp_q = {4'd0, 4'd1, 4'd6, 4'd8};
         T_I:     exp_q = {4'd0, 4'd1, 4'd7, 4'd8};
         T_BEQ:   exp_q = {4'd0, 4'd1, 4'd9};
         T_JAL:   exp_q = {4'd0, 4'd1, 4'd10, 4'd8};
         default: exp_q = {4'd0, 4'd1, 4'd11};
      endcase
   endfunction

   // Runs one legal instruction from FETCH; zmode 0=random zero, 1=zero high, 2=zero low.
   task automatic run_instr(input logic [6:0] o, input int zmode, input string tag);
      logic [3:0] s;
      int cyc;
      op = o;
      load_trace(o);
      cyc = 0;
      while (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         exp_v = exp_vec(int'(s), zero, 1'b1, o);
         checks++;
         if (obs_h !== exp_v) begin
            errors++;
            $display("FAIL %s cyc%0d halt-dut: got %b want %b", tag, cyc, obs_h, exp_v);
         end
         checks++;
         if (obs_p !== exp_v) begin
            errors++;
            $display("FAIL %s cyc%0d nohalt-dut: got %b want %b", tag, cyc, obs_p, exp_v);
         end
         cyc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op = T_R; zero = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_v = exp_vec(0, zero, 1'b0, op);
      checks++;
      if (obs_h !== exp_v || obs_p !== exp_v) begin
         errors++;
         $display("FAIL reset_hold: got %b/%b want %b", obs_h, obs_p, exp_v);
      end
      rst_n = 1'b1;
      #1;
      exp_v = exp_vec(0, zero, 1'b1, op);
      checks++;
      if (obs_h !== exp_v || obs_p !== exp_v) begin
         errors++;
         $display("FAIL reset_release: got %b/%b want %b", obs_h, obs_p, exp_v);
      end
   endtask

   task automatic test_rtype();
      run_instr(T_R, 0, "rtype");
      run_instr(T_I, 0, "itype");
   endtask

   task automatic test_lw_sw();
      run_instr(T_LW, 0, "lw");
      run_instr(T_SW, 0, "sw");
   endtask

   task automatic test_beq();
      run_instr(T_BEQ, 1, "beq_taken");
      run_instr(T_BEQ, 2, "beq_not_taken");
      op = T_BEQ; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      zero = 1'b1; #1;
      checks++;
      if (h_state !== 4'd9 || h_pcWrite !== 1'b1 || h_aluOp !== 2'b01 || h_immSrc !== 2'b10) begin
         errors++;
         $display("FAIL beq_zero_rise: got st=%0d pcw=%b aop=%b imm=%b want 9 1 01 10",
                  h_state, h_pcWrite, h_aluOp, h_immSrc);
      end
      zero = 1'b0; #1;
      checks++;
      if (h_pcWrite !== 1'b0) begin
         errors++;
         $display("FAIL beq_zero_fall: got pcWrite=%b want 0", h_pcWrite);
      end
      @(posedge clk); #1;
      checks++;
      if (h_state !== 4'd0) begin
         errors++;
         $display("FAIL beq_return: got state=%0d want 0", h_state);
      end
   endtask

   task automatic test_jal();
      run_instr(T_JAL, 0, "jal");
   endtask

   // Enters ILLEGAL from FETCH, watches both variants, then resets back to FETCH.
   task automatic test_illegal();
      logic [3:0] pat[3];
      pat[0] = 4'd0; pat[1] = 4'd1; pat[2] = 4'd11;
      op = T_BAD;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k <= 6; k++) begin
         zero = 1'($urandom_range(0, 1));
         #1;
         exp_v = exp_vec(11, zero, 1'b1, op);
         exp_p = (k == 0) ? exp_v : exp_vec(int'(pat[(k - 1) % 3]), zero, 1'b1, op);
         checks++;
         if (obs_h !== exp_v) begin
            errors++;
            $display("FAIL illegal_halt k%0d: got %b want %b", k, obs_h, exp_v);
         end
         checks++;
         if (obs_p !== exp_p) begin
            errors++;
            $display("FAIL illegal_nohalt k%0d: got %b want %b", k, obs_p, exp_p);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0; #1;
      checks++;
      if (h_trap !== 1'b0 || h_state !== 4'd11) begin
         errors++;
         $display("FAIL illegal_rst_mask: got trap=%b state=%0d want 0 11", h_trap, h_state);
      end
      @(posedge clk); #1;
      checks++;
      if (h_state !== 4'd0 || p_state !== 4'd0) begin
         errors++;
         $display("FAIL illegal_rst_exit: got %0d/%0d want 0/0", h_state, p_state);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_write();
      op = T_SW; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (h_state !== 4'd5 || h_memWrite !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: got state=%0d memWrite=%b want 5 1", h_state, h_memWrite);
      end
      rst_n = 1'b0; #1;
      exp_v = exp_vec(5, zero, 1'b0, op);
      checks++;
      if (obs_h !== exp_v) begin
         errors++;
         $display("FAIL midrst_mask: got %b want %b", obs_h, exp_v);
      end
      @(posedge clk); #1;
      exp_v = exp_vec(0, zero, 1'b0, op);
      checks++;
      if (obs_h !== exp_v || obs_p !== exp_v) begin
         errors++;
         $display("FAIL midrst_after: got %b/%b want %b", obs_h, obs_p, exp_v);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [6:0] ops[6];
      ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R;
      ops[3] = T_I;  ops[4] = T_BEQ; ops[5] = T_JAL;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) test_illegal();
         else run_instr(ops[$urandom_range(0, 5)], 0, "random");
      end
   endtask

   initial begin
      rst_n = 1'b0; op = 7'd0; zero = 1'b0;
      test_reset();
      test_rtype();
      test_lw_sw();
      test_beq();
      test_jal();
      test_illegal();
      test_reset_mid_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
